// File: rtl/vga_pkg.sv
// Shared constants, state encoding and one-hot helpers for the tile scheduler.
package vga_pkg;

  localparam int AREA_NUM   = 6;
  localparam int AREA_SIZE  = 200;
  localparam int CELL_SHIFT = 3;
  // Enough bits to number every 8-pixel cell across one 200-pixel area (0..24).
  localparam int CELL_BITS  = $clog2(((AREA_SIZE - 1) >> CELL_SHIFT) + 1);
  localparam int IDX_W      = 3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PENDING = 2'd1,
    ST_SWAP    = 2'd2
  } sched_state_t;

  function automatic logic is_onehot(input logic [AREA_NUM-1:0] a);
    return (a != '0) && ((a & (a - {{(AREA_NUM-1){1'b0}}, 1'b1})) == '0);
  endfunction

  function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [AREA_NUM-1:0] a);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < AREA_NUM; i++) begin
      if (a[i]) idx = idx | IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/vga_tile_scheduler_if.sv
// CPU-side request/acknowledge bus used to retarget area tile IDs.
interface vga_tile_scheduler_if #(
  parameter int TILE_W = 4
);
  logic              cpu_req;
  logic              cpu_commit;
  logic [2:0]        cpu_idx;
  logic [TILE_W-1:0] cpu_tile;
  logic              cpu_ack;
  logic              cpu_err;
  logic              commit_busy;

  modport master (
    output cpu_req, cpu_commit, cpu_idx, cpu_tile,
    input  cpu_ack, cpu_err, commit_busy
  );

  modport slave (
    input  cpu_req, cpu_commit, cpu_idx, cpu_tile,
    output cpu_ack, cpu_err, commit_busy
  );
endinterface

// File: rtl/vga_tile_table.sv
// Six-entry shadow/active tile-ID register file; swap copies shadow to active in one cycle.
module vga_tile_table
  import vga_pkg::*;
#(
  parameter int TILE_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [TILE_W-1:0] wr_tile,
  input  logic              swap,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [TILE_W-1:0] rd_tile
);

  logic [TILE_W-1:0] shadow_reg [AREA_NUM];
  logic [TILE_W-1:0] active_reg [AREA_NUM];

  generate
    for (genvar gi = 0; gi < AREA_NUM; gi++) begin : g_entry
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          shadow_reg[gi] <= '0;
        end else if (wr_en && (wr_idx == IDX_W'(gi))) begin
          shadow_reg[gi] <= wr_tile;
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          active_reg[gi] <= '0;
        end else if (swap) begin
          active_reg[gi] <= shadow_reg[gi];
        end
      end
    end
  endgenerate

  assign rd_tile = (rd_idx < IDX_W'(AREA_NUM)) ? active_reg[rd_idx] : '0;

endmodule

// File: rtl/vga_tile_scheduler.sv
// Tile-pattern fetch sequencer for the 2x3 area grid with tear-free, vblank-timed table commits.
module vga_tile_scheduler
  import vga_pkg::*;
#(
  parameter int TILE_W  = 4,
  parameter int ROM_LAT = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          vblank_start,
  input  logic [AREA_NUM-1:0]           area,
  input  logic [9:0]                    relative_x,
  input  logic [9:0]                    relative_y,
  vga_tile_scheduler_if.slave           cpu,
  output logic                          rom_en,
  output logic [TILE_W+2*CELL_BITS-1:0] rom_addr,
  output logic                          pix_active
);

  sched_state_t         state_reg;
  logic                 ack_reg;
  logic                 err_reg;
  logic                 busy_reg;
  logic                 req_held_reg;

  logic [AREA_NUM-1:0]  area_reg;
  logic [9:0]           rel_x_reg;
  logic [9:0]           rel_y_reg;
  logic [ROM_LAT-1:0]   pix_pipe_reg;

  logic                 accept;
  logic                 idx_ok;
  logic                 wr_en;
  logic                 swap;
  logic                 area_valid;
  logic [IDX_W-1:0]     area_idx;
  logic [TILE_W-1:0]    tile_rd;
  logic [CELL_BITS-1:0] cell_x;
  logic [CELL_BITS-1:0] cell_y;

  // A request is taken once per assertion, and only when no commit is in flight.
  assign accept = cpu.cpu_req && !req_held_reg && (state_reg == ST_IDLE);
  assign idx_ok = cpu.cpu_idx < IDX_W'(AREA_NUM);
  assign wr_en  = accept && !cpu.cpu_commit && idx_ok;
  assign swap   = (state_reg == ST_SWAP);

  vga_tile_table #(
    .TILE_W (TILE_W)
  ) u_table (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_idx  (cpu.cpu_idx),
    .wr_tile (cpu.cpu_tile),
    .swap    (swap),
    .rd_idx  (area_idx),
    .rd_tile (tile_rd)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      ack_reg      <= 1'b0;
      err_reg      <= 1'b0;
      busy_reg     <= 1'b0;
      req_held_reg <= 1'b0;
    end else begin
      ack_reg <= accept;
      err_reg <= accept && !cpu.cpu_commit && !idx_ok;
      if (!cpu.cpu_req) begin
        req_held_reg <= 1'b0;
      end else if (accept) begin
        req_held_reg <= 1'b1;
      end
      case (state_reg)
        ST_IDLE: begin
          if (accept && cpu.cpu_commit) begin
            state_reg <= ST_PENDING;
            busy_reg  <= 1'b1;
          end
        end
        ST_PENDING: begin
          if (vblank_start) state_reg <= ST_SWAP;
        end
        ST_SWAP: begin
          state_reg <= ST_IDLE;
          busy_reg  <= 1'b0;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign cpu.cpu_ack     = ack_reg;
  assign cpu.cpu_err     = err_reg;
  assign cpu.commit_busy = busy_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      area_reg  <= '0;
      rel_x_reg <= '0;
      rel_y_reg <= '0;
    end else begin
      area_reg  <= area;
      rel_x_reg <= relative_x;
      rel_y_reg <= relative_y;
    end
  end

  assign area_valid = is_onehot(area_reg);
  assign area_idx   = onehot_to_idx(area_reg);
  // Positions are 1-based; shift the 0-based offset down to an 8x8 cell index.
  assign cell_x     = CELL_BITS'((rel_x_reg - 10'd1) >> CELL_SHIFT);
  assign cell_y     = CELL_BITS'((rel_y_reg - 10'd1) >> CELL_SHIFT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rom_en   <= 1'b0;
      rom_addr <= '0;
    end else begin
      rom_en <= area_valid;
      if (area_valid) rom_addr <= {tile_rd, cell_y, cell_x};
    end
  end

  generate
    for (genvar gi = 0; gi < ROM_LAT; gi++) begin : g_pix_delay
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          pix_pipe_reg[gi] <= 1'b0;
        end else if (gi == 0) begin
          pix_pipe_reg[gi] <= rom_en;
        end else begin
          pix_pipe_reg[gi] <= pix_pipe_reg[(gi > 0) ? gi - 1 : 0];
        end
      end
    end
  endgenerate

  assign pix_active = pix_pipe_reg[ROM_LAT-1];

endmodule
